// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and constants for the SAR conversion sequencer
//
// Purpose : state encoding, default resolution and debug-mux select codes
//           used by sar_sequencer and its bit-pointer sub-module.
// Ports   : none (package).
package sar_pkg;

  localparam int SAR_N_BITS_DEFAULT = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAMPLE  = 3'd1,
    ST_CONVERT = 3'd2,
    ST_OFFSET  = 3'd3,
    ST_DONE    = 3'd4
  } sar_state_e;

  localparam logic [2:0] DBG_IDLE    = 3'd0;
  localparam logic [2:0] DBG_SAMPLE  = 3'd1;
  localparam logic [2:0] DBG_CONVERT = 3'd2;
  localparam logic [2:0] DBG_OFFSET  = 3'd3;
  localparam logic [2:0] DBG_DONE    = 3'd4;
  localparam logic [2:0] DBG_EN_COMP = 3'd5;
  localparam logic [2:0] DBG_COMP_P  = 3'd6;
  localparam logic [2:0] DBG_COMP_N  = 3'd7;

endpackage

// File: rtl/sar_bit_ptr.sv
// rtl/sar_bit_ptr.sv - one-hot pointer to the bit currently under trial
//
// Purpose : walks a single 1 from the top trial bit down to bit 0.
// Ports   : clk, rst          clock, async active-high reset
//           load_i, load_se_i load pointer (MSB, or MSB-1 when load_se_i)
//           shift_i           advance pointer one bit towards the LSB
//           ptr_o             one-hot pointer
//           last_o            pointer sits on bit 0 (final decision)
module sar_bit_ptr
  import sar_pkg::*;
#(
  parameter int N_BITS = SAR_N_BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              load_se_i,
  input  logic              shift_i,
  output logic [N_BITS-1:0] ptr_o,
  output logic              last_o
);

  localparam logic [N_BITS-1:0] MSB_ONE = {1'b1, {(N_BITS-1){1'b0}}};

  logic [N_BITS-1:0] ptr_q;
  logic [N_BITS-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      // single-ended skips the sign bit, so the walk starts one bit lower
      ptr_d = load_se_i ? (MSB_ONE >> 1) : MSB_ONE;
    end else if (shift_i) begin
      ptr_d = ptr_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign last_o = ptr_q[0];

endmodule

// File: rtl/sar_sequencer.sv
// rtl/sar_sequencer.sv - successive-approximation ADC conversion sequencer
//
// Purpose : sample / bit-by-bit convert / optional offset-cal / done sequence
//           driving the trial DAC word and collecting comparator decisions.
// Ports   : clk, rst                       clock, async active-high reset
//           start, abort, continuous       conversion control
//           single_ended, en_offset_cal    conversion mode
//           sample_len                     sample phase length minus one
//           comp_p, comp_n                 comparator outputs
//           debug_sel, debug_out           debug observation mux
//           sample_o, en_comp              sampling switch / comparator enable
//           offset_cal_cycle, busy         phase indicators
//           dac_code                       trial DAC word
//           result, result_valid, comp_err conversion result and status
module sar_sequencer
  import sar_pkg::*;
#(
  parameter int N_BITS = SAR_N_BITS_DEFAULT,
  parameter int SLEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic              single_ended,
  input  logic              en_offset_cal,
  input  logic [SLEN_W-1:0] sample_len,
  input  logic              comp_p,
  input  logic              comp_n,
  input  logic [2:0]        debug_sel,
  output logic              sample_o,
  output logic              en_comp,
  output logic              offset_cal_cycle,
  output logic              busy,
  output logic              result_valid,
  output logic              comp_err,
  output logic              debug_out,
  output logic [N_BITS-1:0] dac_code,
  output logic [N_BITS-1:0] result
);

  sar_state_e        state_q, state_d;
  logic              se_q, se_d;
  logic              cont_q, cont_d;
  logic              cal_q, cal_d;
  logic [SLEN_W-1:0] slen_q, slen_d;
  logic [SLEN_W-1:0] cnt_q, cnt_d;
  logic [N_BITS-1:0] code_q, code_d;
  logic [N_BITS-1:0] result_q, result_d;
  logic              err_q, err_d;

  logic              ptr_load, ptr_shift, ptr_last;
  logic [N_BITS-1:0] ptr;
  logic              comp_ok;

  sar_bit_ptr #(.N_BITS(N_BITS)) u_bit_ptr (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ptr_load),
    .load_se_i(se_q),
    .shift_i  (ptr_shift),
    .ptr_o    (ptr),
    .last_o   (ptr_last)
  );

  // identical comparator outputs mean no valid decision was made
  assign comp_ok = comp_p ^ comp_n;

  always_comb begin
    state_d   = state_q;
    se_d      = se_q;
    cont_d    = cont_q;
    cal_d     = cal_q;
    slen_d    = slen_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    result_d  = result_q;
    err_d     = err_q;
    ptr_load  = 1'b0;
    ptr_shift = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SAMPLE;
          se_d    = single_ended;
          cont_d  = continuous;
          cal_d   = en_offset_cal;
          slen_d  = sample_len;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == slen_q) begin
          state_d  = ST_CONVERT;
          ptr_load = 1'b1;
          code_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CONVERT: begin
        code_d = (code_q & ~ptr) | ((comp_p && comp_ok) ? ptr : '0);
        if (!comp_ok) begin
          err_d = 1'b1;
        end
        if (ptr_last) begin
          state_d = cal_q ? ST_OFFSET : ST_DONE;
        end else begin
          ptr_shift = 1'b1;
        end
      end
      ST_OFFSET: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        result_d = code_q;
        if (cont_q) begin
          state_d = ST_SAMPLE;
          se_d    = single_ended;
          cont_d  = continuous;
          cal_d   = en_offset_cal;
          slen_d  = sample_len;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // abort freezes everything except the return to IDLE
    if (abort) begin
      state_d   = ST_IDLE;
      se_d      = se_q;
      cont_d    = cont_q;
      cal_d     = cal_q;
      slen_d    = slen_q;
      cnt_d     = cnt_q;
      code_d    = code_q;
      result_d  = result_q;
      err_d     = err_q;
      ptr_load  = 1'b0;
      ptr_shift = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      se_q     <= 1'b0;
      cont_q   <= 1'b0;
      cal_q    <= 1'b0;
      slen_q   <= '0;
      cnt_q    <= '0;
      code_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      se_q     <= se_d;
      cont_q   <= cont_d;
      cal_q    <= cal_d;
      slen_q   <= slen_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // comparator strobes on the low half of the clock, decision taken at the rising edge
  assign en_comp          = ~clk & ((state_q == ST_CONVERT) || (state_q == ST_OFFSET));
  assign sample_o         = (state_q == ST_SAMPLE);
  assign offset_cal_cycle = (state_q == ST_OFFSET);
  assign busy             = (state_q != ST_IDLE);
  assign result_valid     = (state_q == ST_DONE) && !abort;
  assign comp_err         = err_q;
  // the register captures on leaving DONE; during DONE the fresh code is forwarded
  assign result           = result_valid ? code_q : result_q;

  always_comb begin
    case (state_q)
      ST_CONVERT:        dac_code = code_q | ptr;
      ST_OFFSET, ST_DONE: dac_code = code_q;
      default:           dac_code = '0;
    endcase
  end

  always_comb begin
    case (debug_sel)
      DBG_IDLE:    debug_out = (state_q == ST_IDLE);
      DBG_SAMPLE:  debug_out = (state_q == ST_SAMPLE);
      DBG_CONVERT: debug_out = (state_q == ST_CONVERT);
      DBG_OFFSET:  debug_out = (state_q == ST_OFFSET);
      DBG_DONE:    debug_out = (state_q == ST_DONE);
      DBG_EN_COMP: debug_out = en_comp;
      DBG_COMP_P:  debug_out = comp_p;
      DBG_COMP_N:  debug_out = comp_n;
      default:     debug_out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sar_sequencer.sv
// tb/tb_sar_sequencer.sv - scoreboard testbench for sar_sequencer
module tb_sar_sequencer;

  localparam int P_IDLE = 0, P_SAMPLE = 1, P_CONV = 2, P_OFF = 3, P_DONE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic        single_ended = 1'b0, en_offset_cal = 1'b0;
  logic [3:0]  sample_len = 4'd0;
  logic        comp_p = 1'b0, comp_n = 1'b1;
  logic [2:0]  debug_sel = 3'd0;
  logic        sample_o, en_comp, offset_cal_cycle, busy, result_valid, comp_err, debug_out;
  logic [11:0] dac_code, result;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [11:0] exp_q[$];

  sar_sequencer #(.N_BITS(12), .SLEN_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .continuous      (continuous),
    .single_ended    (single_ended),
    .en_offset_cal   (en_offset_cal),
    .sample_len      (sample_len),
    .comp_p          (comp_p),
    .comp_n          (comp_n),
    .debug_sel       (debug_sel),
    .sample_o        (sample_o),
    .en_comp         (en_comp),
    .offset_cal_cycle(offset_cal_cycle),
    .busy            (busy),
    .result_valid    (result_valid),
    .comp_err        (comp_err),
    .debug_out       (debug_out),
    .dac_code        (dac_code),
    .result          (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    start = 0; abort = 0; continuous = 0; comp_p = 0; comp_n = 1;
    tick();
    tick();
  endtask

  // Cycle 1 is the cycle following the edge that samples start.
  task automatic run_conv(input int slen, input bit se, input bit cal, input bit cont,
                          input logic [11:0] pat, input int errbit, input int ncyc,
                          input int abort_cyc, input bit hold_start, input int exp_lat);
    int nb, top, per, k, c, b, ph, first_valid;
    bit aborted, have_last;
    logic [11:0] exp_code, exp_res, exp_dac, last_res;
    logic dec;
    nb = se ? 11 : 12;
    top = nb - 1;
    per = slen + 2 + nb + (cal ? 1 : 0);
    first_valid = 0; aborted = 0; have_last = 0;
    exp_code = '0; last_res = '0;
    single_ended = se; en_offset_cal = cal; continuous = cont;
    sample_len = slen[3:0]; debug_sel = 3'd2; abort = 0; start = 1;
    tick();
    if (!hold_start) start = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      k = (cyc - 1) / per;
      c = (cyc - 1) % per + 1;
      b = 0;
      if (aborted || (k > 0 && !cont)) ph = P_IDLE;
      else if (c <= slen + 1) ph = P_SAMPLE;
      else if (c <= slen + 1 + nb) begin ph = P_CONV; b = top - (c - slen - 2); end
      else if (cal && c == slen + 2 + nb) ph = P_OFF;
      else ph = P_DONE;

      if (ph == P_SAMPLE && c == 1) begin
        exp_code = '0;
        exp_res = '0;
        for (int i = top; i >= 0; i--) exp_res[i] = (i == errbit) ? 1'b0 : pat[i];
        exp_q.push_back(exp_res);
      end

      if (ph == P_CONV) exp_dac = exp_code | (12'd1 << b);
      else if (ph == P_OFF || ph == P_DONE) exp_dac = exp_code;
      else exp_dac = '0;

      chk_cnt++;
      if (sample_o !== (ph == P_SAMPLE)) begin
        err_cnt++; $display("FAIL sample_o cyc=%0d got %b want %b", cyc, sample_o, ph == P_SAMPLE);
      end
      chk_cnt++;
      if (busy !== (ph != P_IDLE)) begin
        err_cnt++; $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, ph != P_IDLE);
      end
      chk_cnt++;
      if (result_valid !== (ph == P_DONE)) begin
        err_cnt++; $display("FAIL result_valid cyc=%0d got %b want %b", cyc, result_valid, ph == P_DONE);
      end
      chk_cnt++;
      if (offset_cal_cycle !== (ph == P_OFF)) begin
        err_cnt++; $display("FAIL offset_cal_cycle cyc=%0d got %b want %b", cyc, offset_cal_cycle, ph == P_OFF);
      end
      chk_cnt++;
      if (dac_code !== exp_dac) begin
        err_cnt++; $display("FAIL dac_code cyc=%0d got %h want %h", cyc, dac_code, exp_dac);
      end
      chk_cnt++;
      if (debug_out !== (ph == P_CONV)) begin
        err_cnt++; $display("FAIL debug_convert cyc=%0d got %b want %b", cyc, debug_out, ph == P_CONV);
      end
      chk_cnt++;
      if (en_comp !== 1'b0) begin
        err_cnt++; $display("FAIL en_comp_high_phase cyc=%0d got %b want 0", cyc, en_comp);
      end
      if (ph == P_DONE) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++; $display("FAIL scoreboard_empty cyc=%0d got result %h want queued entry", cyc, result);
        end else begin
          exp_res = exp_q.pop_front();
          if (result !== exp_res) begin
            err_cnt++; $display("FAIL result cyc=%0d got %h want %h", cyc, result, exp_res);
          end
          last_res = exp_res;
          have_last = 1;
          if (first_valid == 0) first_valid = cyc;
        end
      end

      dec = 1'b0;
      if (ph == P_CONV) begin
        dec = (b == errbit) ? 1'b0 : pat[b];
        comp_p = pat[b];
        comp_n = (b == errbit) ? pat[b] : ~pat[b];
      end else if (ph == P_OFF) begin
        comp_p = 1; comp_n = 1;
      end else begin
        comp_p = 0; comp_n = 1;
      end
      abort = (cyc == abort_cyc);
      if (cyc == ncyc) start = 0;

      @(negedge clk);
      #1;
      chk_cnt++;
      if (en_comp !== (ph == P_CONV || ph == P_OFF)) begin
        err_cnt++; $display("FAIL en_comp_low_phase cyc=%0d got %b want %b", cyc, en_comp, ph == P_CONV || ph == P_OFF);
      end

      if (ph == P_CONV && cyc != abort_cyc) exp_code[b] = dec;
      if (cyc == abort_cyc) begin
        aborted = 1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
      end
      tick();
    end
    abort = 0; start = 0; comp_p = 0; comp_n = 1;
    if (exp_lat > 0) begin
      chk_cnt++;
      if (first_valid != exp_lat) begin
        err_cnt++; $display("FAIL latency got %0d want %0d", first_valid, exp_lat);
      end
    end
    if (abort_cyc > 0 && have_last) begin
      chk_cnt++;
      if (result !== last_res) begin
        err_cnt++; $display("FAIL result_after_abort got %h want %h", result, last_res);
      end
    end
    chk_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++; $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    chk_cnt++;
    if ({busy, sample_o, result_valid, comp_err, offset_cal_cycle} !== 5'b0) begin
      err_cnt++; $display("FAIL reset_flags got %b want 00000", {busy, sample_o, result_valid, comp_err, offset_cal_cycle});
    end
    chk_cnt++;
    if (result !== 12'h000 || dac_code !== 12'h000) begin
      err_cnt++; $display("FAIL reset_words got %h/%h want 000/000", result, dac_code);
    end
    debug_sel = 3'd0;
    #1;
    chk_cnt++;
    if (debug_out !== 1'b1) begin
      err_cnt++; $display("FAIL reset_debug_idle got %b want 1", debug_out);
    end
    rst = 0;
    sample_len = 4'd1;
    start = 1;
    tick();
    start = 0;
    chk_cnt++;
    if (busy !== 1'b1 || sample_o !== 1'b1) begin
      err_cnt++; $display("FAIL start_after_reset got busy=%b sample=%b want 1 1", busy, sample_o);
    end
    abort = 1;
    tick();
    abort = 0;
    chk_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++; $display("FAIL abort_from_sample got %b want 0", busy);
    end
    settle();
  endtask

  task automatic test_diff();
    run_conv(1, 0, 0, 0, 12'hAAA, -1, 17, 0, 0, 15);
    settle();
  endtask

  task automatic test_single_ended();
    run_conv(1, 1, 0, 0, 12'hFFF, -1, 16, 0, 0, 14);
    settle();
  endtask

  task automatic test_offset_cal();
    run_conv(3, 0, 1, 0, 12'h35C, -1, 20, 0, 0, 18);
    chk_cnt++;
    if (comp_err !== 1'b0) begin
      err_cnt++; $display("FAIL offset_no_err got %b want 0", comp_err);
    end
    settle();
  endtask

  task automatic test_start_ignored();
    run_conv(2, 0, 0, 0, 12'h5C3, -1, 16, 0, 1, 16);
    settle();
  endtask

  task automatic test_continuous_abort();
    run_conv(1, 0, 0, 1, 12'h3C5, -1, 40, 36, 0, 15);
    settle();
  endtask

  task automatic test_comp_err();
    run_conv(1, 0, 0, 0, 12'h5A5, 5, 16, 0, 0, 15);
    chk_cnt++;
    if (comp_err !== 1'b1) begin
      err_cnt++; $display("FAIL comp_err_set got %b want 1", comp_err);
    end
    tick();
    chk_cnt++;
    if (comp_err !== 1'b1) begin
      err_cnt++; $display("FAIL comp_err_sticky got %b want 1", comp_err);
    end
    start = 1;
    tick();
    start = 0;
    chk_cnt++;
    if (comp_err !== 1'b0) begin
      err_cnt++; $display("FAIL comp_err_clear got %b want 0", comp_err);
    end
    abort = 1;
    tick();
    settle();
  endtask

  task automatic test_abort_idle();
    start = 1; abort = 1;
    tick();
    chk_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++; $display("FAIL abort_wins_over_start got %b want 0", busy);
    end
    chk_cnt++;
    if (result !== 12'h585) begin
      err_cnt++; $display("FAIL result_hold got %h want 585", result);
    end
    settle();
  endtask

  task automatic test_reset_mid_convert();
    sample_len = 4'd1; single_ended = 0; en_offset_cal = 0;
    start = 1;
    tick();
    start = 0;
    comp_p = 1; comp_n = 0;
    for (int i = 0; i < 5; i++) tick();
    chk_cnt++;
    if (dac_code === 12'h000 || busy !== 1'b1) begin
      err_cnt++; $display("FAIL pre_reset_convert got dac=%h busy=%b want nonzero 1", dac_code, busy);
    end
    rst = 1;
    #2;
    chk_cnt++;
    if ({busy, sample_o, result_valid, comp_err, offset_cal_cycle, en_comp} !== 6'b0) begin
      err_cnt++; $display("FAIL async_reset_flags got %b want 000000", {busy, sample_o, result_valid, comp_err, offset_cal_cycle, en_comp});
    end
    chk_cnt++;
    if (result !== 12'h000 || dac_code !== 12'h000) begin
      err_cnt++; $display("FAIL async_reset_words got %h/%h want 000/000", result, dac_code);
    end
    rst = 0;
    settle();
  endtask

  initial begin
    test_reset();
    test_diff();
    test_single_ended();
    test_offset_cal();
    test_start_ignored();
    test_continuous_abort();
    test_comp_err();
    test_abort_idle();
    test_reset_mid_convert();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
